// File: rtl/lfsr_burst_arbiter.sv
// Round-robin owner of one external LFSR: seeds it, streams a burst of words, pulses done.
// Grant in the cycle after a request is sampled; first word one cycle later; done one cycle after the last handshake.
// Backpressure: with i_Data_Ready low the LFSR is frozen and o_Data holds its value.
module lfsr_burst_arbiter #(
    parameter int NUM_BITS = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    input  logic [1:0]          i_Req,
    input  logic [NUM_BITS-1:0] i_Seed_0,
    input  logic [NUM_BITS-1:0] i_Seed_1,
    input  logic [CNT_BITS-1:0] i_Len_0,
    input  logic [CNT_BITS-1:0] i_Len_1,
    output logic [1:0]          o_Gnt,
    output logic [1:0]          o_Done,
    output logic [NUM_BITS-1:0] o_Data,
    output logic                o_Data_Valid,
    input  logic                i_Data_Ready,
    output logic                o_Data_Owner,
    output logic                o_Wrap,
    output logic                o_LFSR_Enable,
    output logic                o_LFSR_Seed_DV,
    output logic [NUM_BITS-1:0] o_LFSR_Seed_Data,
    input  logic [NUM_BITS-1:0] i_LFSR_Data,
    input  logic                i_LFSR_Done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [NUM_BITS-1:0] seed_q, seed_d;
    logic [CNT_BITS-1:0] len_q, len_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic                win_vld;
    logic                win_idx;
    logic                hs;
    logic                last_word;

    // When both request, the one not served last wins.
    always_comb begin
        win_vld = |i_Req;
        win_idx = 1'b0;
        case (i_Req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_q;
            default: win_idx = 1'b0;
        endcase
    end

    assign hs        = (state_q == ST_RUN) && i_Data_Ready;
    assign last_word = (cnt_q == (len_q - CNT_BITS'(1)));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        seed_d  = seed_q;
        len_d   = len_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    owner_d = win_idx;
                    gnt_d   = win_idx ? 2'b10 : 2'b01;
                    seed_d  = win_idx ? i_Seed_1 : i_Seed_0;
                    len_d   = win_idx ? i_Len_1 : i_Len_0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = (len_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (hs) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                    if (last_word) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                last_d  = owner_q;
                owner_d = 1'b0;
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            gnt_q   <= 2'b00;
            seed_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            seed_q  <= seed_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // The LFSR compares against its seed input, so keep the latched seed on it for the whole burst.
    always_comb begin
        o_Gnt            = gnt_q;
        o_Data_Owner     = owner_q;
        o_Done           = 2'b00;
        o_Data           = '0;
        o_Data_Valid     = 1'b0;
        o_Wrap           = 1'b0;
        o_LFSR_Enable    = 1'b0;
        o_LFSR_Seed_DV   = 1'b0;
        o_LFSR_Seed_Data = '0;

        case (state_q)
            ST_LOAD: begin
                o_LFSR_Enable    = 1'b1;
                o_LFSR_Seed_DV   = 1'b1;
                o_LFSR_Seed_Data = seed_q;
            end
            ST_RUN: begin
                o_Data_Valid     = 1'b1;
                o_Data           = i_LFSR_Data;
                o_LFSR_Enable    = hs;
                o_LFSR_Seed_Data = seed_q;
                o_Wrap           = hs && i_LFSR_Done && (cnt_q != '0);
            end
            ST_DONE: begin
                o_Done           = {owner_q, ~owner_q};
                o_LFSR_Seed_Data = seed_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Bench for lfsr_burst_arbiter with a 4-bit XNOR LFSR (x^4+x^3+1) attached.
module tb_lfsr_burst_arbiter;

    localparam int NB = 4;
    localparam int CB = 16;

    logic          i_Clk = 1'b0;
    logic          i_Rst_L;
    logic [1:0]    i_Req;
    logic [NB-1:0] i_Seed_0, i_Seed_1;
    logic [CB-1:0] i_Len_0, i_Len_1;
    logic [1:0]    o_Gnt, o_Done;
    logic [NB-1:0] o_Data;
    logic          o_Data_Valid;
    logic          i_Data_Ready = 1'b1;
    logic          o_Data_Owner, o_Wrap, o_LFSR_Enable, o_LFSR_Seed_DV;
    logic [NB-1:0] o_LFSR_Seed_Data;
    logic [NB-1:0] i_LFSR_Data;
    logic          i_LFSR_Done;

    lfsr_burst_arbiter #(.NUM_BITS(NB), .CNT_BITS(CB)) dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Req(i_Req),
        .i_Seed_0(i_Seed_0), .i_Seed_1(i_Seed_1), .i_Len_0(i_Len_0), .i_Len_1(i_Len_1),
        .o_Gnt(o_Gnt), .o_Done(o_Done), .o_Data(o_Data), .o_Data_Valid(o_Data_Valid),
        .i_Data_Ready(i_Data_Ready), .o_Data_Owner(o_Data_Owner), .o_Wrap(o_Wrap),
        .o_LFSR_Enable(o_LFSR_Enable), .o_LFSR_Seed_DV(o_LFSR_Seed_DV),
        .o_LFSR_Seed_Data(o_LFSR_Seed_Data), .i_LFSR_Data(i_LFSR_Data), .i_LFSR_Done(i_LFSR_Done)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [NB-1:0] step(input logic [NB-1:0] v);
        return {v[NB-2:0], ~(v[NB-1] ^ v[NB-2])};
    endfunction

    // Attached LFSR peripheral (no reset, as in the real part).
    logic [NB-1:0] lfsr_q = '0;
    always @(posedge i_Clk)
        if (o_LFSR_Enable) lfsr_q <= o_LFSR_Seed_DV ? o_LFSR_Seed_Data : step(lfsr_q);
    assign i_LFSR_Data = lfsr_q;
    assign i_LFSR_Done = (lfsr_q == o_LFSR_Seed_Data);

    typedef struct packed {
        logic          owner;
        logic [NB-1:0] data;
        logic          wrap;
    } word_t;

    word_t exp_w[$];
    int    exp_d[$];
    int    total = 0, bad = 0;
    int    cyc = 0, hs_cnt = 0, done_seen = 0, done_cyc = 0, last_hs_cyc = 0;
    int    rdy_mode = 0;
    int    rr_last = 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got event want none", nm);
    endtask

    // Expected words of a burst: word k is the seed advanced k times.
    task automatic push_burst(input int n, input logic [NB-1:0] seed, input int len);
        logic [NB-1:0] v;
        v = seed;
        for (int k = 0; k < len; k++) begin
            exp_w.push_back('{owner: (n != 0), data: v, wrap: (k != 0) && (v == seed)});
            v = step(v);
        end
        exp_d.push_back(n);
    endtask

    // Monitor / scoreboard
    always @(negedge i_Clk) begin
        int o;
        cyc++;
        if (i_Rst_L) begin
            if (o_Gnt == 2'b11) flag("gnt_onehot");
            if (o_Data_Valid) begin
                if (exp_w.size() == 0) flag("unexpected_word");
                else begin
                    check("data", 32'(o_Data), 32'(exp_w[0].data));
                    if (i_Data_Ready) begin
                        check("wrap", 32'(o_Wrap), 32'(exp_w[0].wrap));
                        check("owner", 32'(o_Data_Owner), 32'(exp_w[0].owner));
                        check("gnt_run", 32'(o_Gnt), exp_w[0].owner ? 32'd2 : 32'd1);
                        void'(exp_w.pop_front());
                        hs_cnt++;
                        last_hs_cyc = cyc;
                    end else if (o_Wrap) flag("wrap_stall");
                end
            end else begin
                check("idle_data", 32'(o_Data), 32'd0);
                if (o_Wrap) flag("wrap_idle");
            end
            if (o_Done != 2'b00) begin
                if (exp_d.size() == 0) flag("unexpected_done");
                else begin
                    o = exp_d.pop_front();
                    check("done", 32'(o_Done), (o != 0) ? 32'd2 : 32'd1);
                    done_seen++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial forever begin
        @(posedge i_Clk);
        #1;
        case (rdy_mode)
            0:       i_Data_Ready = 1'b1;
            1:       i_Data_Ready = ~i_Data_Ready;
            default: i_Data_Ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check_zero(input string nm);
        check({nm, "_gnt"}, 32'(o_Gnt), 32'd0);
        check({nm, "_done"}, 32'(o_Done), 32'd0);
        check({nm, "_data"}, 32'(o_Data), 32'd0);
        check({nm, "_vld"}, 32'(o_Data_Valid), 32'd0);
        check({nm, "_own"}, 32'(o_Data_Owner), 32'd0);
        check({nm, "_wrap"}, 32'(o_Wrap), 32'd0);
        check({nm, "_en"}, 32'(o_LFSR_Enable), 32'd0);
        check({nm, "_sdv"}, 32'(o_LFSR_Seed_DV), 32'd0);
        check({nm, "_seed"}, 32'(o_LFSR_Seed_Data), 32'd0);
    endtask

    task automatic wait_done(input int n_done, input int budget);
        int d0, w;
        d0 = done_seen;
        w  = 0;
        while (done_seen < d0 + n_done && w < budget) begin
            @(negedge i_Clk);
            #1;
            w++;
        end
        if (done_seen < d0 + n_done) flag("done_timeout");
    endtask

    task automatic run_burst(input int n, input logic [NB-1:0] seed, input int len);
        int w, gcyc;
        @(posedge i_Clk);
        #1;
        if (n == 0) begin i_Seed_0 = seed; i_Len_0 = CB'(len); end
        else        begin i_Seed_1 = seed; i_Len_1 = CB'(len); end
        push_burst(n, seed, len);
        rr_last  = n;
        i_Req[n] = 1'b1;
        w = 0;
        do begin
            @(negedge i_Clk);
            #1;
            w++;
        end while (o_Gnt == 2'b00 && w < 10);
        gcyc = cyc;
        check("req_to_gnt", 32'(w), 32'd2);
        check("gnt_owner", 32'(o_Gnt), (n != 0) ? 32'd2 : 32'd1);
        wait_done(1, 4 * len + 40);
        if (len == 0) check("zero_len_done_lat", 32'(done_cyc - gcyc), 32'd1);
        else          check("done_after_last_hs", 32'(done_cyc - last_hs_cyc), 32'd1);
        if (rdy_mode == 0) check("burst_cycles", 32'(done_cyc - gcyc), 32'(len + 1));
        @(posedge i_Clk);
        #1;
        i_Req[n] = 1'b0;
        @(negedge i_Clk);
        check("gnt_release", 32'(o_Gnt), 32'd0);
    endtask

    task automatic contention(input int l0, input int l1);
        int first;
        logic [NB-1:0] s0, s1;
        @(posedge i_Clk);
        #1;
        s0 = NB'($urandom); s1 = NB'($urandom);
        i_Seed_0 = s0; i_Seed_1 = s1;
        i_Len_0 = CB'(l0); i_Len_1 = CB'(l1);
        first = (rr_last == 1) ? 0 : 1;
        for (int k = 0; k < 3; k++) begin
            if ((k % 2 == 0) == (first == 0)) push_burst(0, s0, l0);
            else                              push_burst(1, s1, l1);
        end
        rr_last = first;
        i_Req = 2'b11;
        wait_done(3, 4 * (l0 + l1) + 100);
        @(posedge i_Clk);
        #1;
        i_Req = 2'b00;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        i_Rst_L = 1'b0; i_Req = 2'b00;
        i_Seed_0 = '0; i_Seed_1 = '0; i_Len_0 = '0; i_Len_1 = '0;
        repeat (3) @(posedge i_Clk);
        #1;
        check_zero("reset");
        i_Rst_L = 1'b1;

        rdy_mode = 0; run_burst(0, 4'h0, 4);
        rdy_mode = 1; run_burst(0, 4'h0, 4);
        rdy_mode = 0; contention(2, 2);
        run_burst(0, 4'h0, 16);
        run_burst(1, 4'hF, 3);
        run_burst(0, 4'h5, 0);

        // Reset in the middle of a burst
        begin
            int h0, w;
            @(posedge i_Clk);
            #1;
            i_Seed_0 = 4'h9; i_Len_0 = 16'd8;
            push_burst(0, 4'h9, 8);
            i_Req[0] = 1'b1;
            h0 = hs_cnt; w = 0;
            while (hs_cnt < h0 + 2 && w < 40) begin
                @(negedge i_Clk);
                #1;
                w++;
            end
            if (hs_cnt < h0 + 2) flag("mid_reset_timeout");
            i_Rst_L = 1'b0;
            i_Req   = 2'b00;
            exp_w.delete();
            exp_d.delete();
            rr_last = 1;
            #1;
            check_zero("mid_reset");
            repeat (2) @(posedge i_Clk);
            #1;
            check_zero("mid_reset_hold");
            i_Rst_L = 1'b1;
            run_burst(0, 4'h9, 5);
        end

        for (int i = 0; i < 12; i++) begin
            rdy_mode = $urandom_range(0, 2);
            if (i % 4 == 3) contention($urandom_range(0, 5), $urandom_range(0, 5));
            else run_burst($urandom_range(0, 1), NB'($urandom), $urandom_range(0, 20));
        end
        rdy_mode = 0;
        repeat (4) @(posedge i_Clk);
        check("exp_words_left", 32'(exp_w.size()), 32'd0);
        check("exp_done_left", 32'(exp_d.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
